gray_edge_outline: RTL and testbench

GRAY_EDGE_OUTLINE -- requirements
Module: gray_edge_outline

---
 rtl/gray_style_pkg.sv | 22 ++
 rtl/gray_line_buffer.sv | 39 +++
 rtl/gray_edge_outline.sv | 142 ++++++++++++++
 tb/tb_gray_edge_outline.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gray_style_pkg.sv
// Shared definitions for the gray-stage video blocks.
// Provides the pixel and gradient widths, default line geometry and edge
// threshold, the outline FSM state type and a small absolute-difference helper.
package gray_style_pkg;

    localparam int PIX_W               = 8;
    localparam int GRAD_W              = 9;
    localparam int H_ACTIVE_DEFAULT    = 640;
    localparam int EDGE_THRESH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FIRST_ROW = 2'd1,
        BODY      = 2'd2
    } grayState_e;

    function automatic logic [PIX_W-1:0] absDiff(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/gray_line_buffer.sv
// Single line store for the edge outliner.
// Ports:
//   clk            - write/read clock
//   rdEn, rdAddr   - synchronous read request; rdData valid one cycle later
//   rdData         - registered read data (holds when rdEn is low)
//   wrEn, wrAddr,
//   wrData         - write port
// A read and write to the same address in one cycle returns the old contents.
// No reset on the storage so it maps onto block RAM.
module gray_line_buffer
    import gray_style_pkg::*;
#(
    parameter int DEPTH  = H_ACTIVE_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [PIX_W-1:0]  rdData,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [PIX_W-1:0]  wrData
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/gray_edge_outline.sv
// Edge outliner for the quantized gray stream.
// Each pixel is compared with its left neighbour and the pixel above it; when
// the summed absolute difference reaches EDGE_THRESH the pixel is drawn black,
// otherwise it passes through. Fixed two-cycle latency, no backpressure.
// Ports:
//   i_clk, i_rst_n          - clock, asynchronous active-low reset
//   i_valid, i_sof, i_sol   - input qualifiers (sof/sol ignored when !i_valid)
//   iGray                   - input gray pixel
//   o_valid, o_sof, o_sol   - qualifiers delayed by two cycles
//   oRed, oGreen, oBlue     - outlined pixel, identical on all channels
module gray_edge_outline
    import gray_style_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEFAULT,
    parameter int EDGE_THRESH = EDGE_THRESH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_sof,
    input  logic             i_sol,
    input  logic [PIX_W-1:0] iGray,
    output logic             o_valid,
    output logic             o_sof,
    output logic             o_sol,
    output logic [PIX_W-1:0] oRed,
    output logic [PIX_W-1:0] oGreen,
    output logic [PIX_W-1:0] oBlue
);

    localparam int                COL_W     = $clog2(H_ACTIVE + 1);
    localparam int                ADDR_W    = $clog2(H_ACTIVE);
    localparam logic [COL_W-1:0]  COL_LIMIT = COL_W'(H_ACTIVE);
    localparam logic [GRAD_W-1:0] THRESH    = GRAD_W'(EDGE_THRESH);

    grayState_e        state, nextState;
    logic [COL_W-1:0]  col, colCur;
    logic [PIX_W-1:0]  leftPix, leftCur;
    logic              inRange;
    logic [PIX_W-1:0]  rdData;

    logic              s1Valid, s1Sof, s1Sol, s1Test, s1UpSelf;
    logic [PIX_W-1:0]  s1Pix, s1Left;
    logic [PIX_W-1:0]  upPix, outPix;
    logic [GRAD_W-1:0] grad;

    // The state a pixel is judged in is the one its own sof/sol moves us to,
    // so the first pixel of a frame already sees FIRST_ROW.
    always_comb begin
        nextState = state;
        if (i_valid) begin
            if (i_sof) begin
                nextState = FIRST_ROW;
            end else if (i_sol && state == FIRST_ROW) begin
                nextState = BODY;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        colCur  = (i_sof || i_sol) ? '0 : col;
        inRange = colCur < COL_LIMIT;
        leftCur = (colCur == '0) ? iGray : leftPix;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col     <= '0;
            leftPix <= '0;
        end else if (i_valid) begin
            col     <= inRange ? colCur + COL_W'(1) : COL_LIMIT;
            leftPix <= iGray;
        end
    end

    gray_line_buffer #(
        .DEPTH  (H_ACTIVE),
        .ADDR_W (ADDR_W)
    ) lineBuf (
        .clk    (i_clk),
        .rdEn   (i_valid && inRange),
        .rdAddr (ADDR_W'(colCur)),
        .rdData (rdData),
        .wrEn   (i_valid && inRange),
        .wrAddr (ADDR_W'(colCur)),
        .wrData (iGray)
    );

    // Stage 1 lines up with the buffer's registered read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1Valid  <= 1'b0;
            s1Sof    <= 1'b0;
            s1Sol    <= 1'b0;
            s1Test   <= 1'b0;
            s1UpSelf <= 1'b0;
            s1Pix    <= '0;
            s1Left   <= '0;
        end else begin
            s1Valid  <= i_valid;
            s1Sof    <= i_valid && i_sof;
            s1Sol    <= i_valid && i_sol;
            s1Test   <= inRange && (nextState != IDLE);
            s1UpSelf <= (nextState == FIRST_ROW);
            s1Pix    <= iGray;
            s1Left   <= leftCur;
        end
    end

    always_comb begin
        upPix  = s1UpSelf ? s1Pix : rdData;
        grad   = {1'b0, absDiff(s1Pix, s1Left)} + {1'b0, absDiff(s1Pix, upPix)};
        outPix = (s1Test && grad >= THRESH) ? '0 : s1Pix;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_sol   <= 1'b0;
            oRed    <= '0;
            oGreen  <= '0;
            oBlue   <= '0;
        end else begin
            o_valid <= s1Valid;
            o_sof   <= s1Sof;
            o_sol   <= s1Sol;
            oRed    <= outPix;
            oGreen  <= outPix;
            oBlue   <= outPix;
        end
    end

endmodule

// File: tb/tb_gray_edge_outline.sv
// Directed self-checking bench for gray_edge_outline (640 columns, threshold 32).
module tb_gray_edge_outline;

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_sof   = 1'b0;
    logic       i_sol   = 1'b0;
    logic [7:0] iGray   = 8'h00;
    logic       o_valid, o_sof, o_sol;
    logic [7:0] oRed, oGreen, oBlue;

    typedef struct {
        logic       sof;
        logic       sol;
        logic [7:0] pix;
    } expPix_t;

    expPix_t    expQ[$];
    int         nChecks = 0;
    int         nErrors = 0;
    logic [1:0] validHist;

    gray_edge_outline #(
        .H_ACTIVE    (640),
        .EDGE_THRESH (32)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .i_sof   (i_sof),
        .i_sol   (i_sol),
        .iGray   (iGray),
        .o_valid (o_valid),
        .o_sof   (o_sof),
        .o_sol   (o_sol),
        .oRed    (oRed),
        .oGreen  (oGreen),
        .oBlue   (oBlue)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkVal(input string tag, input int got, input int want);
        nChecks++;
        if (got != want) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // i_valid as sampled at the last two rising edges.
    always @(posedge i_clk) begin
        if (!i_rst_n) validHist <= 2'b00;
        else          validHist <= {validHist[0], i_valid};
    end

    always @(negedge i_clk) begin
        expPix_t e;
        if (i_rst_n) begin
            checkVal("o_valid latency", int'(o_valid), int'(validHist[1]));
            if (o_valid) begin
                if (expQ.size() == 0) begin
                    checkVal("output without expectation", int'(o_valid), 0);
                end else begin
                    e = expQ.pop_front();
                    checkVal("oRed",   int'(oRed),   int'(e.pix));
                    checkVal("oGreen", int'(oGreen), int'(e.pix));
                    checkVal("oBlue",  int'(oBlue),  int'(e.pix));
                    checkVal("o_sof",  int'(o_sof),  int'(e.sof));
                    checkVal("o_sol",  int'(o_sol),  int'(e.sol));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic sof, input logic sol,
                         input logic [7:0] pix, input logic [7:0] expOut);
        @(posedge i_clk);
        #2;
        i_valid = v;
        i_sof   = sof;
        i_sol   = sol;
        iGray   = pix;
        if (v) expQ.push_back('{sof, sol, expOut});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic checkZero(input string tag);
        checkVal({tag, " o_valid"}, int'(o_valid), 0);
        checkVal({tag, " o_sof"},   int'(o_sof),   0);
        checkVal({tag, " o_sol"},   int'(o_sol),   0);
        checkVal({tag, " oRed"},    int'(oRed),    0);
        checkVal({tag, " oGreen"},  int'(oGreen),  0);
        checkVal({tag, " oBlue"},   int'(oBlue),   0);
    endtask

    function automatic logic [7:0] stepPix(input int c);
        return (c < 320) ? 8'h00 : 8'hF0;
    endfunction

    // Vertical step: only the first bright column differs from its left.
    function automatic logic [7:0] stepExp(input int c);
        return (c == 320) ? 8'h00 : stepPix(c);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checkZero("reset");
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        idle(3);

        // Flat frame 640x4 of 0x80
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 640; c++)
                drive(1'b1, r == 0 && c == 0, c == 0, 8'h80, 8'h80);
        idle(4);

        // Vertical step
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 640; c++)
                drive(1'b1, r == 0 && c == 0, c == 0, stepPix(c), stepExp(c));
        idle(4);

        // Horizontal step: first row uses itself as up, second row sees 0x30 jump
        for (int c = 0; c < 640; c++) drive(1'b1, c == 0, c == 0, 8'h10, 8'h10);
        for (int c = 0; c < 640; c++) drive(1'b1, 1'b0, c == 0, 8'h40, 8'h00);
        idle(4);

        // Out-of-range columns pass through untouched
        for (int c = 0; c < 640; c++) drive(1'b1, c == 0, c == 0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
        drive(1'b1, 1'b0, 1'b0, 8'h80, 8'h80);
        idle(4);

        // Threshold boundary, short lines
        drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h1F, 8'h1F);   // left diff 31
        drive(1'b1, 1'b0, 1'b0, 8'h3F, 8'h00);   // left diff 32
        drive(1'b1, 1'b0, 1'b1, 8'h1F, 8'h1F);   // up diff 31
        drive(1'b1, 1'b0, 1'b0, 8'h20, 8'h20);   // 1 + 1
        drive(1'b1, 1'b0, 1'b0, 8'h40, 8'h00);   // 32 + 1
        idle(4);

        // Gapped valid; the idle cycle carries junk that must be ignored
        drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 8'h30, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
        idle(4);

        // Reset in the middle of row 2
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 640; c++)
                drive(1'b1, r == 0 && c == 0, c == 0, stepPix(c), stepExp(c));
        for (int c = 0; c < 100; c++) drive(1'b1, 1'b0, c == 0, stepPix(c), stepExp(c));
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_sol   = 1'b0;
        expQ.delete();
        repeat (2) begin
            @(negedge i_clk);
            checkZero("mid reset");
        end
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        for (int c = 100; c < 640; c++) drive(1'b1, 1'b0, 1'b0, stepPix(c), stepPix(c));
        for (int c = 0; c < 640; c++) drive(1'b1, 1'b0, c == 0, stepPix(c), stepPix(c));
        idle(4);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 640; c++)
                drive(1'b1, r == 0 && c == 0, c == 0, stepPix(c), stepExp(c));
        idle(4);

        for (int k = 0; k < 20 && expQ.size() > 0; k++) @(posedge i_clk);
        checkVal("drain", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
